// File: rtl/audio_mixer.sv
// Multi-channel sample player: fetches one sample per channel per tick,
// mixes around the midpoint with saturation and drives a PWM output.
module audio_mixer #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 13,
    parameter int TICK_DIV = 3125
) (
    input  logic                       clk_25MHZ,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          start,
    input  logic [NUM_CH-1:0]          stop,
    input  logic [NUM_CH-1:0]          loop,
    input  logic [NUM_CH*ADDR_W-1:0]   base_addr,
    input  logic [NUM_CH*ADDR_W-1:0]   length,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [SAMPLE_W-1:0]        mem_data,
    output logic [NUM_CH-1:0]          busy,
    output logic                       pwm_out,
    output logic                       en
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(NUM_CH + 3);
    localparam int MW = SAMPLE_W + $clog2(NUM_CH + 1) + 2;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [PW-1:0] LAST_PH = PW'(NUM_CH + 2);
    localparam logic signed [MW-1:0] S_MID = MW'(2 ** (SAMPLE_W - 1));
    localparam logic signed [MW-1:0] S_MAX = MW'(2 ** SAMPLE_W - 1);

    logic [TW-1:0]       r_tick_cnt;
    logic                w_tick;
    logic [PW-1:0]       r_phase;
    logic [NUM_CH-1:0]   r_play;
    logic [NUM_CH-1:0]   r_loop;
    logic [NUM_CH-1:0]   r_pend;
    logic [ADDR_W-1:0]   r_base  [NUM_CH];
    logic [ADDR_W-1:0]   r_len   [NUM_CH];
    logic [ADDR_W-1:0]   r_off   [NUM_CH];
    logic [ADDR_W-1:0]   r_faddr [NUM_CH];
    logic [SAMPLE_W-1:0] r_smp   [NUM_CH];
    logic [SAMPLE_W-1:0] r_mix;
    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic                r_pwm;
    logic signed [MW-1:0] w_acc;
    logic [SAMPLE_W-1:0] w_mix;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Phase k means cycle T+k after the tick; 0 means sequencer idle.
    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= PW'(1);
        end else if (r_phase == LAST_PH) begin
            r_phase <= '0;
        end else if (r_phase != '0) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_play <= '0;
            r_loop <= '0;
            r_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_base[i]  <= '0;
                r_len[i]   <= '0;
                r_off[i]   <= '0;
                r_faddr[i] <= '0;
                r_smp[i]   <= MID;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (start[i] && length[i*ADDR_W +: ADDR_W] != '0) begin
                    r_play[i] <= 1'b1;
                    r_loop[i] <= loop[i];
                    r_base[i] <= base_addr[i*ADDR_W +: ADDR_W];
                    r_len[i]  <= length[i*ADDR_W +: ADDR_W];
                    r_off[i]  <= '0;
                end else if (stop[i] && r_play[i]) begin
                    r_play[i] <= 1'b0;
                    r_pend[i] <= 1'b0;
                end else if (w_tick && r_play[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_faddr[i] <= r_base[i] + r_off[i];
                    if (r_off[i] == r_len[i] - 1'b1) begin
                        r_off[i] <= '0;
                        if (!r_loop[i]) r_play[i] <= 1'b0;
                    end else begin
                        r_off[i] <= r_off[i] + 1'b1;
                    end
                end
                // Data returns one cycle after this channel's read slot.
                if (r_phase == PW'(i + 2)) begin
                    r_smp[i]  <= r_pend[i] ? mem_data : MID;
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_phase == PW'(i + 1) && r_pend[i]) begin
                mem_rd   = 1'b1;
                mem_addr = r_faddr[i];
            end
        end
    end

    always_comb begin
        w_acc = S_MID;
        for (int i = 0; i < NUM_CH; i++) begin
            w_acc = w_acc + $signed(MW'(r_smp[i])) - S_MID;
        end
        if (w_acc[MW-1]) begin
            w_mix = '0;
        end else if (w_acc > S_MAX) begin
            w_mix = '1;
        end else begin
            w_mix = w_acc[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk_25MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_mix     <= MID;
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (r_phase == LAST_PH) r_mix <= w_mix;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pwm     <= (r_pwm_cnt < r_mix);
        end
    end

    assign busy    = r_play;
    assign en      = |r_play;
    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: expected read addresses are queued
// per channel at stimulus time and checked by a negedge monitor.
module tb_audio_mixer;

    localparam int NCH = 2;
    localparam int SW  = 8;
    localparam int AW  = 13;
    localparam int TD  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    start = '0;
    logic [NCH-1:0]    stop = '0;
    logic [NCH-1:0]    loop_i = '0;
    logic [NCH*AW-1:0] base_addr = '0;
    logic [NCH*AW-1:0] length = '0;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [SW-1:0]     mem_data = '0;
    logic [NCH-1:0]    busy;
    logic              pwm_out;
    logic              en;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int unsigned q0[$];
    int unsigned q1[$];

    audio_mixer #(
        .NUM_CH(NCH), .SAMPLE_W(SW), .ADDR_W(AW), .TICK_DIV(TD)
    ) dut (
        .clk_25MHZ(clk), .rst_n(rst_n),
        .start(start), .stop(stop), .loop(loop_i),
        .base_addr(base_addr), .length(length),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .pwm_out(pwm_out), .en(en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem_addr[7:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Channel i owns the read slot one cycle plus i after each tick.
    always @(negedge clk) begin
        int ph;
        int unsigned e;
        if (rst_n && mem_rd) begin
            ph = cyc % TD;
            if (ph == 0 && q0.size() > 0) begin
                e = q0.pop_front();
                chk("rd_addr_ch0", int'(mem_addr), int'(e));
            end else if (ph == 1 && q1.size() > 0) begin
                e = q1.pop_front();
                chk("rd_addr_ch1", int'(mem_addr), int'(e));
            end else begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got addr %0d in slot %0d want no read",
                         mem_addr, ph);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_to(input int ph);
        do step(); while (cyc % TD != ph);
    endtask

    task automatic set_ch(input int ch, input int b, input int l, input bit lp);
        base_addr[ch*AW +: AW] = AW'(b);
        length[ch*AW +: AW]    = AW'(l);
        loop_i[ch]             = lp;
    endtask

    task automatic pulse(input logic [NCH-1:0] s, input logic [NCH-1:0] p);
        start = s;
        stop  = p;
        step();
        start = '0;
        stop  = '0;
    endtask

    task automatic push(input int ch, input int b, input int l, input int n);
        int unsigned a;
        for (int j = 0; j < n; j++) begin
            a = int'((b + j % l) % (1 << AW));
            if (ch == 0) q0.push_back(a);
            else q1.push_back(a);
        end
    endtask

    task automatic duty(input string nm, input int exp);
        int c = 0;
        repeat (256) begin
            step();
            if (pwm_out) c++;
        end
        chk(nm, c, exp);
    endtask

    task automatic drain(input string nm);
        adv_to(4);
        adv_to(4);
        chk(nm, q0.size() + q1.size(), 0);
    endtask

    task automatic mixcase(input string nm, input int b0, input int b1, input bit use1);
        int s0;
        int s1;
        int m;
        s0 = b0 % 256;
        s1 = use1 ? b1 % 256 : 128;
        m  = 128 + (s0 - 128) + (s1 - 128);
        if (m < 0) m = 0;
        if (m > 255) m = 255;
        adv_to(4);
        set_ch(0, b0, 1, 1'b1);
        set_ch(1, b1, 1, 1'b1);
        push(0, b0, 1, 19);
        if (use1) push(1, b1, 1, 19);
        pulse({use1, 1'b1}, '0);
        repeat (32) step();
        duty(nm, m);
        adv_to(4);
        pulse('0, {use1, 1'b1});
        drain({nm, "_drain"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b[2];
        int l[2];
        int n[2];
        int lp[2];
        int rd;
        int expb;
        int maxn;
        logic [NCH-1:0] sv;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_pwm", pwm_out, 0);
        #2 rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        duty("idle_duty", 128);

        adv_to(4);
        set_ch(0, 100, 3, 1'b0);
        push(0, 100, 3, 3);
        pulse(2'b01, '0);
        chk("one_busy_start", busy[0], 1);
        for (int t = 1; t <= 3; t++) begin
            adv_to(0);
            chk("one_busy_tick", busy[0], (t < 3) ? 1 : 0);
            chk("one_en_tick", en, (t < 3) ? 1 : 0);
        end
        drain("one_drain");

        adv_to(4);
        set_ch(1, 200, 2, 1'b1);
        push(1, 200, 2, 4);
        pulse(2'b10, '0);
        chk("loop_busy", busy[1], 1);
        repeat (4) adv_to(4);
        pulse('0, 2'b10);
        chk("loop_stop_busy", busy[1], 0);
        chk("loop_stop_en", en, 0);
        drain("loop_drain");

        adv_to(4);
        set_ch(0, 300, 4, 1'b0);
        push(0, 300, 4, 2);
        pulse(2'b01, '0);
        adv_to(4);
        adv_to(4);
        push(0, 300, 4, 4);
        pulse(2'b01, '0);
        chk("restart_busy", busy[0], 1);
        repeat (4) adv_to(4);
        chk("restart_done", busy[0], 0);
        drain("restart_drain");

        adv_to(4);
        set_ch(0, 50, 1, 1'b0);
        push(0, 50, 1, 1);
        pulse(2'b01, 2'b01);
        chk("startstop_busy", busy[0], 1);
        drain("startstop_drain");
        chk("startstop_done", busy[0], 0);

        adv_to(4);
        set_ch(1, 70, 0, 1'b0);
        pulse(2'b10, '0);
        chk("len0_busy", busy[1], 0);
        chk("len0_en", en, 0);
        drain("len0_drain");

        mixcase("mix_255_200", 255, 200, 1'b1);
        mixcase("mix_0_0", 0, 256, 1'b1);
        mixcase("mix_200_100", 200, 100, 1'b1);
        mixcase("mix_128_idle", 128, 0, 1'b0);

        for (int it = 0; it < 20; it++) begin
            adv_to(4);
            expb = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                b[ch]  = $urandom_range(0, (1 << AW) - 1);
                l[ch]  = $urandom_range(0, 5);
                lp[ch] = $urandom_range(0, 1);
                n[ch]  = $urandom_range(1, 6);
                set_ch(ch, b[ch], l[ch], lp[ch][0]);
                if (l[ch] == 0) rd = 0;
                else if (lp[ch] != 0) rd = n[ch];
                else rd = (n[ch] < l[ch]) ? n[ch] : l[ch];
                push(ch, b[ch], (l[ch] == 0) ? 1 : l[ch], rd);
                if (l[ch] != 0) expb |= (1 << ch);
            end
            pulse(2'b11, '0);
            chk("rnd_busy_start", busy, expb);
            maxn = (n[0] > n[1]) ? n[0] : n[1];
            for (int t = 1; t <= maxn; t++) begin
                adv_to(4);
                sv = '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    if (t == n[ch]) sv[ch] = 1'b1;
                end
                pulse('0, sv);
            end
            drain("rnd_drain");
            chk("rnd_busy_end", busy, 0);
        end

        adv_to(4);
        set_ch(0, 400, 3, 1'b1);
        pulse(2'b01, '0);
        adv_to(0);
        chk("pre_rst_rd", mem_rd, 1);
        chk("pre_rst_addr", int'(mem_addr), 400);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd", mem_rd, 0);
        chk("midrst_addr", int'(mem_addr), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_en", en, 0);
        chk("midrst_pwm", pwm_out, 0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        duty("post_rst_duty", 128);
        drain("post_rst_drain");
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent playback channels.
REQ-002 SHALL have parameter SAMPLE_W, default 8: unsigned sample width and PWM resolution.
REQ-003 SHALL have parameter ADDR_W, default 13: sample memory address width.
REQ-004 SHALL have parameter TICK_DIV, default 3125: clk_25MHZ cycles per sample period (8 kHz), legal only if TICK_DIV >= NUM_CH+3.
REQ-005 SHALL have port clk_25MHZ, input, 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, NUM_CH: one-cycle pulse per channel, start or restart playback.
REQ-008 SHALL have port stop, input, NUM_CH: one-cycle pulse per channel, abort playback.
REQ-009 SHALL have port loop, input, NUM_CH: loop mode, sampled only on accepted start.
REQ-010 SHALL have port base_addr, input, NUM_CH*ADDR_W: per-channel first sample address, sampled on start.
REQ-011 SHALL have port length, input, NUM_CH*ADDR_W: per-channel sample count, sampled on start.
REQ-012 SHALL have port mem_rd, output, 1: sample memory read strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W: read address, valid with mem_rd.
REQ-014 SHALL have port mem_data, input, SAMPLE_W: read data, valid exactly one cycle after mem_rd.
REQ-015 SHALL have port busy, output, NUM_CH: channel in PLAY state.
REQ-016 SHALL have port pwm_out, output, 1: registered PWM audio.
REQ-017 SHALL have port en, output, 1: amplifier enable, equal to OR of busy.

Function
REQ-018 SHALL count 0..TICK_DIV-1 and wrap, asserting internal tick in the cycle count equals TICK_DIV-1.
REQ-019 SHALL give each channel states IDLE and PLAY; start with length!=0 enters PLAY from either state, loading base, length, loop, offset=0.
REQ-020 SHALL ignore start with length==0; stop in IDLE no effect; simultaneous start and stop: start wins.
REQ-021 SHALL, on stop in PLAY, return to IDLE next edge and issue no further reads for that channel; an already-pending fetch is cancelled.
REQ-022 SHALL, at each tick in PLAY, snapshot fetch address base+offset (modulo 2^ADDR_W) and mark fetch pending.
REQ-023 SHALL, at the same tick, increment offset unless offset==length-1, then offset=0 if loop else go IDLE (pending fetch still performed).
REQ-024 SHALL issue reads in cycles T+1..T+NUM_CH after tick cycle T, channel i in slot T+1+i; slots of non-pending channels keep mem_rd=0.
REQ-025 SHALL capture mem_data into the channel sample register the cycle after its read; non-pending channels load midpoint M=2^(SAMPLE_W-1) in that slot.
REQ-026 SHALL compute mix = M + sum(sample_i - M) in signed arithmetic wide enough for NUM_CH terms, saturated to [0, 2^SAMPLE_W-1].
REQ-027 SHALL update the mix register at cycle T+NUM_CH+2, holding it otherwise.
REQ-028 SHALL run a free SAMPLE_W-bit PWM counter, wrapping, with pwm_out registered as counter < mix (mix 0 -> constant 0).
REQ-029 SHALL update busy and en in the same cycle as the state change.

Reset
REQ-030 SHALL, while rst_n low, force tick counter 0, all channels IDLE, offsets 0, sample registers M, mix M, PWM counter 0.
REQ-031 SHALL, while rst_n low, force mem_rd=0, mem_addr=0, busy=0, en=0, pwm_out=0.
REQ-032 SHALL abandon any in-flight fetch sequence on reset, with no read issued after reset release until the first tick following an accepted start.

Verification (NUM_CH=2, SAMPLE_W=8, TICK_DIV=16; memory model returns addr[7:0])
REQ-033 SHALL cover: reset mid-playback -> outputs 0 immediately; after release, no start -> pwm_out high 128 of every 256 cycles.
REQ-034 SHALL cover: ch0 start base=100 length=3 loop=0 -> mem_addr 100,101,102 on three ticks; busy[0] falls at third tick; en 0.
REQ-035 SHALL cover: ch1 base=200 length=2 loop=1 -> 200,201,200,201; stop -> busy[1]=0 next cycle, no further mem_rd for ch1.
REQ-036 SHALL cover: sample pairs (255,200)->mix 255; (0,0)->0; (200,100)->172; (128,idle)->128.
REQ-037 SHALL cover: start on ch0 mid-play -> next fetch at base offset 0; start+stop same cycle -> PLAY; start with length=0 -> stays IDLE.
REQ-038 SHALL cover: both channels playing -> ch0 read at T+1, ch1 at T+2, mix update at T+4.
